// File: rtl/transpose_ctrl.sv
// Tiled in-place-style matrix transpose controller: reads CHUNK_SIZE^2 tile into a buffer,
// writes it back transposed at the destination supplied by an external address calculator.
module transpose_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ARR_SIZE   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CHUNK_SIZE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  calc_ctrl,
    output logic [ADDR_WIDTH-1:0] calc_base_addr,
    output logic [ADDR_WIDTH-1:0] calc_chunk_addr,
    input  logic [ADDR_WIDTH-1:0] calc_store_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int W  = DATA_WIDTH / 8;
    localparam int S  = ARR_SIZE * W;
    localparam int NT = ARR_SIZE / CHUNK_SIZE;
    localparam int EW = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;

    localparam logic [ADDR_WIDTH-1:0] A_W  = ADDR_WIDTH'(W);
    localparam logic [ADDR_WIDTH-1:0] A_S  = ADDR_WIDTH'(S);
    localparam logic [ADDR_WIDTH-1:0] A_TR = ADDR_WIDTH'(CHUNK_SIZE * S);
    localparam logic [ADDR_WIDTH-1:0] A_TC = ADDR_WIDTH'(CHUNK_SIZE * W);
    localparam logic [EW-1:0]         ELAST = EW'(CHUNK_SIZE - 1);
    localparam logic [TW-1:0]         TLAST = TW'(NT - 1);

    typedef enum logic [2:0] {IDLE, CALC, CALC_WAIT, READ, WRITE, DONE} state_t;

    state_t                  state;
    logic [TW-1:0]           r, c;
    logic [EW-1:0]           i, j;
    logic [ADDR_WIDTH-1:0]   dst_addr;
    logic [DATA_WIDTH-1:0]   tbuf [CHUNK_SIZE][CHUNK_SIZE];

    logic [EW-1:0]           next_i, next_j;
    logic [TW-1:0]           next_r, next_c;
    logic                    last_elem, last_tile;

    always_comb begin
        last_elem = (i == ELAST) && (j == ELAST);
        last_tile = (r == TLAST) && (c == TLAST);
        next_j    = (j == ELAST) ? '0 : j + EW'(1);
        next_i    = (j == ELAST) ? i + EW'(1) : i;
        next_c    = (c == TLAST) ? '0 : c + TW'(1);
        next_r    = (c == TLAST) ? r + TW'(1) : r;
    end

    function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [ADDR_WIDTH-1:0] b,
                                                        input logic [EW-1:0] ei,
                                                        input logic [EW-1:0] ej);
        return b + ADDR_WIDTH'(ei) * A_S + ADDR_WIDTH'(ej) * A_W;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            calc_ctrl       <= 1'b0;
            calc_base_addr  <= '0;
            calc_chunk_addr <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            dst_addr        <= '0;
            r <= '0; c <= '0; i <= '0; j <= '0;
            for (int a = 0; a < CHUNK_SIZE; a++)
                for (int b = 0; b < CHUNK_SIZE; b++)
                    tbuf[a][b] <= '0;
        end else begin
            done      <= 1'b0;
            calc_ctrl <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    calc_base_addr  <= base_addr;
                    calc_chunk_addr <= base_addr;
                    calc_ctrl       <= 1'b1;
                    busy            <= 1'b1;
                    r <= '0; c <= '0;
                    state <= CALC;
                end
                CALC: state <= CALC_WAIT;
                CALC_WAIT: begin
                    dst_addr <= calc_store_addr;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= calc_chunk_addr;
                    i <= '0; j <= '0;
                    state <= READ;
                end
                READ: if (mem_gnt) begin
                    tbuf[i][j] <= mem_rdata;
                    i <= next_i; j <= next_j;
                    if (last_elem) begin
                        // Element (0,0) of the transposed tile is buffer[0][0], unless the tile is 1x1
                        // and that word is arriving right now.
                        mem_we    <= 1'b1;
                        mem_addr  <= dst_addr;
                        mem_wdata <= (CHUNK_SIZE == 1) ? mem_rdata : tbuf[0][0];
                        state     <= WRITE;
                    end else begin
                        mem_addr <= elem_addr(calc_chunk_addr, next_i, next_j);
                    end
                end
                WRITE: if (mem_gnt) begin
                    i <= next_i; j <= next_j;
                    if (last_elem) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (last_tile) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            r <= next_r; c <= next_c;
                            calc_chunk_addr <= calc_base_addr + ADDR_WIDTH'(next_r) * A_TR
                                             + ADDR_WIDTH'(next_c) * A_TC;
                            calc_ctrl <= 1'b1;
                            state     <= CALC;
                        end
                    end else begin
                        mem_addr  <= elem_addr(dst_addr, next_i, next_j);
                        mem_wdata <= tbuf[next_j][next_i];
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
